mmcm_reset_sequencer: RTL and testbench

Parametrised supervisor for an MMCM clock generator and the reset tree derived from it. It pulses the MMCM reset and waits for LOCKED with a timeout and bounded retries. It qualifies lock stability, then releases N ordered reset stages with programmable spacing. It monitors for lock loss and relocks automatically, and exposes status, a fault flag and counters to the register file.

---
 rtl/mmcm_reset_sequencer.sv | 161 ++++++++++++++++
 tb/tb_mmcm_reset_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mmcm_reset_sequencer.sv
// MMCM lock supervisor: pulses the MMCM reset, qualifies LOCKED, then releases an
// ordered reset tree; relocks automatically on lock loss and flags exhausted retries.
module mmcm_reset_sequencer #(
  parameter int TCQ                = 1,
  parameter int RST_PULSE_CYCLES   = 16,
  parameter int LOCK_TIMEOUT       = 65536,
  parameter int LOCK_STABLE_CYCLES = 256,
  parameter int N_STAGES           = 3,
  parameter int STAGE_DELAY        = 64,
  parameter int MAX_RETRIES        = 4
) (
  input  logic                clk_in,
  input  logic                reset,
  input  logic                mmcm_locked,
  input  logic                force_relock,
  output logic                mmcm_rst,
  output logic [N_STAGES-1:0] rst_stage,
  output logic                ready,
  output logic                fault,
  output logic [3:0]          retry_cnt,
  output logic [15:0]         lock_loss_cnt,
  output logic [2:0]          state
);

  localparam int MAX_AB  = (RST_PULSE_CYCLES > LOCK_TIMEOUT) ? RST_PULSE_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CD  = (LOCK_STABLE_CYCLES > STAGE_DELAY) ? LOCK_STABLE_CYCLES : STAGE_DELAY;
  localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int TW      = $clog2(MAX_CYC) + 1;

  // TCQ only models clock-to-out in behavioural sims; this RTL applies no delay.
  if (TCQ < 0 || N_STAGES < 1 || N_STAGES > 8) begin : g_bad_params
  end

  typedef enum logic [2:0] {
    S_RESET_PULSE = 3'd0,
    S_WAIT_LOCK   = 3'd1,
    S_STABLE      = 3'd2,
    S_RELEASE     = 3'd3,
    S_RUN         = 3'd4,
    S_FAULT       = 3'd5
  } state_t;

  state_t              state_r, state_next;
  logic [TW-1:0]       timer;
  logic [3:0]          stage_idx, stage_idx_next;
  logic [3:0]          retry_next;
  logic                timer_clear, loss_inc;
  logic [1:0]          sync_ff;
  logic                locked_s;
  logic                mmcm_rst_d, ready_d, fault_d;
  logic [N_STAGES-1:0] rst_stage_d;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) sync_ff <= 2'b00;
    else       sync_ff <= {sync_ff[0], mmcm_locked};
  end

  assign locked_s = sync_ff[1];

  // State register plus every registered output and counter.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_r       <= S_RESET_PULSE;
      timer         <= '0;
      stage_idx     <= '0;
      retry_cnt     <= '0;
      lock_loss_cnt <= '0;
      mmcm_rst      <= 1'b1;
      rst_stage     <= '1;
      ready         <= 1'b0;
      fault         <= 1'b0;
    end else begin
      state_r   <= state_next;
      stage_idx <= stage_idx_next;
      retry_cnt <= retry_next;
      if (timer_clear)     timer <= '0;
      else if (timer != '1) timer <= timer + TW'(1);
      if (loss_inc && lock_loss_cnt != 16'hFFFF) lock_loss_cnt <= lock_loss_cnt + 16'd1;
      mmcm_rst  <= mmcm_rst_d;
      rst_stage <= rst_stage_d;
      ready     <= ready_d;
      fault     <= fault_d;
    end
  end

  assign state = state_r;

  always_comb begin
    state_next     = state_r;
    stage_idx_next = stage_idx;
    retry_next     = retry_cnt;
    timer_clear    = 1'b0;
    loss_inc       = 1'b0;
    if (force_relock) begin
      state_next  = S_RESET_PULSE;
      timer_clear = 1'b1;
      if (state_r == S_FAULT) retry_next = '0;
    end else begin
      case (state_r)
        S_RESET_PULSE: if (timer == TW'(RST_PULSE_CYCLES - 1)) begin
          state_next  = S_WAIT_LOCK;
          timer_clear = 1'b1;
        end
        S_WAIT_LOCK: if (locked_s) begin
          state_next  = S_STABLE;
          timer_clear = 1'b1;
        end else if (timer == TW'(LOCK_TIMEOUT - 1)) begin
          timer_clear = 1'b1;
          if (retry_cnt < 4'(MAX_RETRIES)) begin
            retry_next = retry_cnt + 4'd1;
            state_next = S_RESET_PULSE;
          end else begin
            state_next = S_FAULT;
          end
        end
        S_STABLE: if (!locked_s) begin
          state_next  = S_WAIT_LOCK;
          timer_clear = 1'b1;
        end else if (timer == TW'(LOCK_STABLE_CYCLES - 1)) begin
          state_next     = S_RELEASE;
          timer_clear    = 1'b1;
          retry_next     = '0;
          stage_idx_next = '0;
        end
        // Lock loss is checked before the stage tick so it always wins.
        S_RELEASE: if (!locked_s) begin
          state_next  = S_RESET_PULSE;
          timer_clear = 1'b1;
          loss_inc    = 1'b1;
          retry_next  = '0;
        end else if (timer == TW'(STAGE_DELAY - 1)) begin
          timer_clear = 1'b1;
          if (stage_idx == 4'(N_STAGES - 1)) state_next = S_RUN;
          else                               stage_idx_next = stage_idx + 4'd1;
        end
        S_RUN: if (!locked_s) begin
          state_next  = S_RESET_PULSE;
          timer_clear = 1'b1;
          loss_inc    = 1'b1;
          retry_next  = '0;
        end
        S_FAULT: state_next = S_FAULT;
        default: begin
          state_next  = S_RESET_PULSE;
          timer_clear = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    mmcm_rst_d = (state_next == S_RESET_PULSE) || (state_next == S_FAULT);
    ready_d    = (state_next == S_RUN);
    fault_d    = (state_next == S_FAULT);
    for (int i = 0; i < N_STAGES; i++) begin
      rst_stage_d[i] = (state_next != S_RUN) &&
                       !((state_next == S_RELEASE) && (4'(i) <= stage_idx_next));
    end
  end

endmodule

// File: tb/tb_mmcm_reset_sequencer.sv
// Self-checking bench: directed scenarios plus random lock/force/reset traffic,
// compared every cycle against a behavioural model of the supervisor.
module tb_mmcm_reset_sequencer;

  localparam int P_RST = 4;
  localparam int P_TO  = 32;
  localparam int P_STB = 8;
  localparam int P_N   = 3;
  localparam int P_SD  = 4;
  localparam int P_MAX = 2;

  logic           clk_in = 1'b0;
  logic           reset, mmcm_locked, force_relock;
  logic           mmcm_rst, ready, fault;
  logic [P_N-1:0] rst_stage;
  logic [3:0]     retry_cnt;
  logic [15:0]    lock_loss_cnt;
  logic [2:0]     state;

  int checks   = 0;
  int failures = 0;

  // Model: spec state number, cycles spent in that state, counters, synchroniser.
  int m_state, m_cyc, m_retry, m_loss;
  bit m_s1, m_s2;

  mmcm_reset_sequencer #(
    .TCQ(1), .RST_PULSE_CYCLES(P_RST), .LOCK_TIMEOUT(P_TO), .LOCK_STABLE_CYCLES(P_STB),
    .N_STAGES(P_N), .STAGE_DELAY(P_SD), .MAX_RETRIES(P_MAX)
  ) dut (
    .clk_in(clk_in), .reset(reset), .mmcm_locked(mmcm_locked), .force_relock(force_relock),
    .mmcm_rst(mmcm_rst), .rst_stage(rst_stage), .ready(ready), .fault(fault),
    .retry_cnt(retry_cnt), .lock_loss_cnt(lock_loss_cnt), .state(state)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic void modelReset();
    m_state = 0; m_cyc = 0; m_retry = 0; m_loss = 0; m_s1 = 1'b0; m_s2 = 1'b0;
  endfunction

  function automatic void modelEnter(input int s);
    m_state = s;
    m_cyc   = 0;
  endfunction

  function automatic void modelLoss();
    if (m_loss < 65535) m_loss++;
    m_retry = 0;
    modelEnter(0);
  endfunction

  function automatic void modelEdge(input bit lk, input bit frc, input bit rst);
    bit lk_s;
    int done;
    if (rst) begin
      modelReset();
      return;
    end
    lk_s = m_s2;
    done = m_cyc + 1;
    m_s2 = m_s1;
    m_s1 = lk;
    if (frc) begin
      if (m_state == 5) m_retry = 0;
      modelEnter(0);
    end else begin
      case (m_state)
        0: if (done == P_RST) modelEnter(1); else m_cyc = done;
        1: if (lk_s) modelEnter(2);
           else if (done == P_TO) begin
             if (m_retry < P_MAX) begin m_retry++; modelEnter(0); end
             else modelEnter(5);
           end else m_cyc = done;
        2: if (!lk_s) modelEnter(1);
           else if (done == P_STB) begin m_retry = 0; modelEnter(3); end
           else m_cyc = done;
        3: if (!lk_s) modelLoss();
           else if (done == P_N * P_SD) modelEnter(4);
           else m_cyc = done;
        4: if (!lk_s) modelLoss(); else m_cyc = done;
        default: m_cyc = done;
      endcase
    end
  endfunction

  // Stage k is released once k*STAGE_DELAY cycles have passed in RELEASE.
  function automatic logic [P_N-1:0] expStage();
    logic [P_N-1:0] v = '1;
    if (m_state == 4) v = '0;
    else if (m_state == 3)
      for (int k = 0; k < P_N; k++) v[k] = (m_cyc < k * P_SD);
    return v;
  endfunction

  task automatic checkAll(input string tag);
    checkOutput({tag, ".state"},     32'(state),         32'(m_state));
    checkOutput({tag, ".mmcm_rst"},  32'(mmcm_rst),      32'(m_state == 0 || m_state == 5));
    checkOutput({tag, ".rst_stage"}, 32'(rst_stage),     32'(expStage()));
    checkOutput({tag, ".ready"},     32'(ready),         32'(m_state == 4));
    checkOutput({tag, ".fault"},     32'(fault),         32'(m_state == 5));
    checkOutput({tag, ".retry"},     32'(retry_cnt),     32'(m_retry));
    checkOutput({tag, ".loss"},      32'(lock_loss_cnt), 32'(m_loss));
  endtask

  task automatic tick();
    @(posedge clk_in);
    modelEdge(mmcm_locked, force_relock, reset);
    #1;
    checkAll("cyc");
  endtask

  task automatic applyStimulus(input bit lk, input bit frc);
    mmcm_locked  = lk;
    force_relock = frc;
    tick();
    force_relock = 1'b0;
  endtask

  // Bounded wait on the model reaching a point; cyc/retry < 0 mean "any".
  task automatic waitFor(input int st, input int cyc, input int retry, input int budget,
                         input string tag);
    int n = 0;
    while (!(m_state == st && (cyc < 0 || m_cyc == cyc) && (retry < 0 || m_retry == retry))
           && n < budget) begin
      tick();
      n++;
    end
    checkOutput({tag, ".reach"}, 32'(state), 32'(st));
  endtask

  task automatic asyncReset(input string tag);
    reset = 1'b1;
    modelReset();
    #1;
    checkAll(tag);
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int run_left;
    reset = 1'b1; mmcm_locked = 1'b0; force_relock = 1'b0;
    modelReset();
    repeat (3) tick();
    reset = 1'b0;

    // Clean start, lock rising at cycle 10
    repeat (10) applyStimulus(1'b0, 1'b0);
    mmcm_locked = 1'b1;
    waitFor(4, -1, -1, 80, "clean");
    repeat (5) applyStimulus(1'b1, 1'b0);

    // Lock loss in RUN, then full relock
    repeat (5) applyStimulus(1'b0, 1'b0);
    mmcm_locked = 1'b1;
    waitFor(4, -1, -1, 80, "relock");

    // force_relock coinciding with lock loss in RUN: no loss counted
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    mmcm_locked = 1'b1;
    waitFor(4, -1, -1, 80, "frc_loss");

    // One-cycle lock drop while qualifying stability
    applyStimulus(1'b1, 1'b1);
    waitFor(2, 5, -1, 40, "stable5");
    applyStimulus(1'b0, 1'b0);
    mmcm_locked = 1'b1;
    waitFor(4, -1, -1, 80, "unstable");

    // force_relock on the exact cycle of a WAIT_LOCK timeout
    applyStimulus(1'b0, 1'b1);
    waitFor(1, P_TO - 1, 1, 150, "to_edge");
    applyStimulus(1'b0, 1'b1);

    // Remaining timeouts run out into FAULT, then force_relock recovers
    waitFor(5, -1, -1, 200, "fault");
    repeat (6) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    mmcm_locked = 1'b1;
    waitFor(4, -1, -1, 80, "recover");

    // Saturated loss counter stays at 0xFFFF
    force dut.lock_loss_cnt = 16'hFFFF;
    m_loss = 65535;
    #1;
    release dut.lock_loss_cnt;
    repeat (5) applyStimulus(1'b0, 1'b0);
    mmcm_locked = 1'b1;
    waitFor(4, -1, -1, 80, "sat");

    // Asynchronous reset after rst_stage[0] has released
    applyStimulus(1'b1, 1'b1);
    waitFor(3, 1, -1, 60, "mid_rel");
    asyncReset("async_rst");

    // Random lock, force and reset traffic
    run_left = 0;
    for (int c = 0; c < 1500; c++) begin
      if (run_left == 0) begin
        mmcm_locked = ~mmcm_locked;
        run_left = mmcm_locked ? $urandom_range(1, 120) : $urandom_range(1, 40);
      end
      run_left--;
      if ($urandom_range(0, 399) == 0) begin
        asyncReset("rand_rst");
      end else begin
        force_relock = ($urandom_range(0, 99) == 0);
        tick();
        force_relock = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
